act_sched: RTL
==============

Name: act_sched

Overview:
- Scheduler that sequences the activation skew reader (`act`).
- Tracks fill status of the two activation SRAM bank groups (group 0 = banks 0/1, group 1 = banks 2/3), which form a ping-pong pair.
- Issues one `start` pulse per 32-row tile to the reader, with a held `tran_time`, and detects tile completion from the reader's `act_out_valid`.
- Mirrors the reader's internal base-row/ping-pong walk so that loader refills and reader consumption never overlap on the same group.

Parameters:
- ROW_NUM, 32, rows per tile (must match reader).
- BANK_DEPTH, 4096, rows per bank group (must match reader).
- TILES_PER_GRP, BANK_DEPTH/ROW_NUM (=128), tiles consumed before the reader toggles group.
- GAP_CYCLES, 2, minimum idle cycles between completion and next `start`.
- TIMEOUT, 1024, max cycles from `start` to first `act_out_valid` rise.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_en  in  1  job launch pulse, sampled only in IDLE
- cfg_tran_time  in  12  per-tile transfer count, latched at launch
- cfg_tile_num  in  16  tiles in job, latched at launch
- abort  in  1  pulse; stop after current tile
- fill_done  in  2  one-cycle pulse per group: loader finished filling group g
- array_ready  in  1  downstream array can accept a tile
- act_out_valid  in  1  from reader
- start  out  1  one-cycle pulse to reader
- tran_time  out  12  to reader; stable from launch until DONE
- grp_free  out  2  group g may be refilled (= ~full[g])
- cur_grp  out  1  group the next tile reads from
- tile_cnt  out  16  tiles completed in current job
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at job end
- err  out  2  sticky: [0] timeout, [1] fill overflow; cleared only by rst_n

Behaviour:
- Reset values:
  - start=0, tran_time=0, grp_free=2'b11, cur_grp=0, tile_cnt=0, busy=0, done=0, err=0.
  - full[1:0]=0, grp_tile_idx=0, state=IDLE.
- Reset mid-operation returns everything to reset values. The reader is reset by the same rst_n, so both restart at group 0, row 0.
- cur_grp and grp_tile_idx persist across jobs; cfg_en never clears them, because the reader's base row persists.
- FSM states: IDLE, WAIT_BUF, ISSUE, RUN, GAP, DONE.
- IDLE:
  - On cfg_en, latch tran_time/tile_num, clear tile_cnt, set busy, go to WAIT_BUF.
  - If cfg_tile_num==0, go straight to DONE instead.
- WAIT_BUF: when full[cur_grp] && array_ready && !abort_pend, go to ISSUE.
- ISSUE: assert start for exactly 1 cycle, clear seen_valid and the timeout counter, go to RUN.
- RUN:
  - Set seen_valid on the first act_out_valid=1.
  - Tile completes on the first cycle with act_out_valid=0 after seen_valid.
  - If TIMEOUT cycles pass without seen_valid, set err[0] and go to DONE.
- On tile completion (last cycle of RUN):
  - tile_cnt+=1 and grp_tile_idx+=1.
  - If grp_tile_idx was TILES_PER_GRP-1: wrap it to 0, clear full[cur_grp], toggle cur_grp.
  - Go to GAP.
- GAP:
  - Count GAP_CYCLES.
  - Then go to DONE if tile_cnt==tile_num or abort_pend; otherwise go to WAIT_BUF.
- DONE: done=1 for 1 cycle; clear busy and abort_pend; go to IDLE.
- abort: sets abort_pend in any non-IDLE state. In WAIT_BUF it exits to DONE next cycle. It never truncates a tile in flight.
- fill_done[g]:
  - Sets full[g].
  - If full[g] is already set and not being cleared that cycle: set err[1] and ignore the pulse.
  - If clear and set hit the same group in the same cycle, the clear is applied first, then the set: result full=1, no error.
- fill_done for both groups in the same cycle: handle each group independently.
- cfg_en outside IDLE is ignored.

Decomposition:
- Package act_sched_pkg holds:
  - the state enum;
  - ROW_NUM, BANK_DEPTH and TILES_PER_GRP as localparams;
  - the err bit indices.
- One natural sub-module, act_grp_tracker: full flags, grp_tile_idx, cur_grp and overflow detection.

Test Plan:
- Launch, single tile:
  - Stimulus: fill_done=2'b01, array_ready=1, then cfg_en with tran_time=7, tile_num=1; model reader drives valid for 8+31 cycles.
  - Required: exactly one start; done 2+GAP cycles after valid falls; tile_cnt=1; cur_grp=0.
- Group wrap:
  - Stimulus: group 0 full, tile_num=130, group 1 filled after tile 100.
  - Required: tile 128 sets grp_free[0]=1 and cur_grp=1; tiles 129-130 issue with no stall; done with tile_cnt=130.
- Buffer stall:
  - Stimulus: tile_num=129 with only group 0 filled.
  - Required: after tile 128, start is withheld, busy=1, grp_free=2'b11; fill_done[1] 50 cycles later, then exactly one start.
- Timeout:
  - Stimulus: act_out_valid held 0 after start.
  - Required: err[0]=1 at start+TIMEOUT; done pulses; tile_cnt=0.
- Overflow and simultaneous set/clear:
  - Stimulus: fill_done[0] while full[0]=1 → err[1]=1.
  - Stimulus: fill_done[0] on the wrap-completion cycle of group 0 → full[0]=1, err[1]=0.
- Abort and reset:
  - Stimulus: abort mid-RUN of tile 3 of 10.
  - Required: tile 3 completes, done pulses, tile_cnt=3.
  - Stimulus: rst_n low mid-RUN.
  - Required: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/act_sched_pkg.sv
// Shared types and constants for the activation scheduler and its group tracker.
package act_sched_pkg;

    localparam int ROW_NUM       = 32;
    localparam int BANK_DEPTH    = 4096;
    localparam int TILES_PER_GRP = BANK_DEPTH / ROW_NUM;
    localparam int TILE_IDX_W    = $clog2(TILES_PER_GRP);
    localparam int GAP_CYCLES    = 2;
    localparam int TIMEOUT       = 1024;
    localparam int TMO_W         = $clog2(TIMEOUT);
    localparam int GAP_W         = $clog2(GAP_CYCLES + 1);

    localparam int ERR_TIMEOUT   = 0;
    localparam int ERR_OVFL      = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_ISSUE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_e;

endpackage

// File: rtl/act_grp_tracker.sv
// Ping-pong bank group bookkeeping: fill flags, reader tile index within the
// current group, and refill-overflow detection.
module act_grp_tracker
    import act_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] fill_done,
    input  logic       tile_done,
    output logic [1:0] full,
    output logic       cur_grp,
    output logic       ovfl
);

    logic [1:0]            full_q, full_d, clr;
    logic [TILE_IDX_W-1:0] idx_q, idx_d;
    logic                  cur_q, cur_d;
    logic                  wrap;

    // A wrap clears the consumed group before any same-cycle refill is applied.
    always_comb begin
        wrap   = tile_done && (idx_q == TILE_IDX_W'(TILES_PER_GRP - 1));
        clr    = 2'b00;
        idx_d  = idx_q;
        cur_d  = cur_q;
        if (wrap) begin
            clr[cur_q] = 1'b1;
            cur_d      = ~cur_q;
        end
        if (tile_done) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        full_d = (full_q & ~clr) | fill_done;
        ovfl   = |(fill_done & full_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
            idx_q  <= '0;
            cur_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
            cur_q  <= cur_d;
        end
    end

    assign full    = full_q;
    assign cur_grp = cur_q;

endmodule

// File: rtl/act_sched.sv
// Tile scheduler for the activation skew reader: waits for a filled group,
// issues one start per tile, detects completion and paces the next tile.
module act_sched
    import act_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic [11:0] cfg_tran_time,
    input  logic [15:0] cfg_tile_num,
    input  logic        abort,
    input  logic [1:0]  fill_done,
    input  logic        array_ready,
    input  logic        act_out_valid,
    output logic        start,
    output logic [11:0] tran_time,
    output logic [1:0]  grp_free,
    output logic        cur_grp,
    output logic [15:0] tile_cnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    state_e           state_q;
    logic [11:0]      tran_time_q;
    logic [15:0]      tile_num_q, tile_cnt_q;
    logic             start_q, done_q, busy_q, abort_pend_q, seen_q;
    logic [1:0]       err_q;
    logic [TMO_W-1:0] tmo_q;
    logic [GAP_W-1:0] gap_q;

    logic [1:0] full;
    logic       cur_grp_w, ovfl, tile_done, abort_any;

    assign tile_done = (state_q == S_RUN) && seen_q && !act_out_valid;
    assign abort_any = abort | abort_pend_q;

    act_grp_tracker u_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_done (fill_done),
        .tile_done (tile_done),
        .full      (full),
        .cur_grp   (cur_grp_w),
        .ovfl      (ovfl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tran_time_q  <= '0;
            tile_num_q   <= '0;
            tile_cnt_q   <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            seen_q       <= 1'b0;
            err_q        <= 2'b00;
            tmo_q        <= '0;
            gap_q        <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (ovfl) err_q[ERR_OVFL] <= 1'b1;
            if (abort && (state_q != S_IDLE)) abort_pend_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_en) begin
                        tran_time_q <= cfg_tran_time;
                        tile_num_q  <= cfg_tile_num;
                        tile_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        if (cfg_tile_num == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_BUF;
                        end
                    end
                end
                S_WAIT_BUF: begin
                    if (abort_any) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (full[cur_grp_w] && array_ready) begin
                        state_q <= S_ISSUE;
                        start_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    seen_q  <= 1'b0;
                    // Loaded so that err is visible exactly TIMEOUT cycles after start.
                    tmo_q   <= TMO_W'(TIMEOUT - 2);
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (!seen_q) begin
                        if (act_out_valid) begin
                            seen_q <= 1'b1;
                        end else if (tmo_q == '0) begin
                            err_q[ERR_TIMEOUT] <= 1'b1;
                            state_q            <= S_DONE;
                            done_q             <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q - 1'b1;
                        end
                    end else if (tile_done) begin
                        tile_cnt_q <= tile_cnt_q + 1'b1;
                        gap_q      <= GAP_W'(GAP_CYCLES - 1);
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        if ((tile_cnt_q == tile_num_q) || abort_any) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_BUF;
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q       <= 1'b0;
                    abort_pend_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start     = start_q;
    assign tran_time = tran_time_q;
    assign grp_free  = ~full;
    assign cur_grp   = cur_grp_w;
    assign tile_cnt  = tile_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
